// File: rtl/cbd_sampler_param_if.sv
// Bus bundle for cbd_sampler_param: PRG word input stream and coefficient beat output stream.
interface cbd_sampler_param_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned N_COEF = 256
) ();

  localparam int unsigned N_BEATS = N_COEF / LANES;
  localparam int unsigned ADDR_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  logic [63:0]             in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*COEF_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDR_W-1:0]       address;
  logic                    done;

  // Environment side: supplies PRG words and accepts coefficient beats.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, address, done
  );

  // Sampler side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, address, done
  );

endinterface

// File: rtl/cbd_sampler_param.sv
// Centered binomial distribution sampler: turns a 64-bit PRG word stream into
// LANES coefficients per beat, negative values encoded as Q+(a-b).
// Optional feature macro: CBD_ETA3_EN (adds eta=3 support and a 128-bit buffer).
module cbd_sampler_param #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned N_COEF = 256,
  parameter int unsigned Q      = 3329
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    eta,
  output logic                    busy,
  cbd_sampler_param_if.slave      bus
);

`ifdef CBD_ETA3_EN
  localparam int unsigned BUF_W  = 128;
  localparam int unsigned C3     = 6 * LANES;
  localparam int unsigned WORDS3 = (N_COEF * 6 + 63) / 64;
`else
  localparam int unsigned BUF_W  = 64 + 4 * LANES;
`endif
  localparam int unsigned C2       = 4 * LANES;
  localparam int unsigned WORDS2   = (N_COEF * 4 + 63) / 64;
  localparam int unsigned CNT_W    = $clog2(BUF_W + 1);
  localparam int unsigned N_BEATS  = N_COEF / LANES;
  localparam int unsigned ADDR_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int unsigned WCNT_W   = $clog2(((N_COEF * 6 + 63) / 64) + 1);
  // A new word is only taken when it is guaranteed to fit above the held bits.
  localparam int unsigned FILL_MAX = BUF_W - 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [WCNT_W-1:0]       words_q, words_d;

  logic [CNT_W-1:0]        cost_c;
  logic [WCNT_W-1:0]       words_req_c;
  logic                    in_ready_c;
  logic                    out_valid_c;
  logic                    fire_in_c;
  logic                    fire_out_c;
  logic                    done_c;
  logic [LANES*COEF_W-1:0] out_data_c;

`ifdef CBD_ETA3_EN
  logic                    eta3_q, eta3_d;
`else
  logic                    unused_eta;
  assign unused_eta = eta;
`endif

  // Map one (a, b) popcount pair onto the modular coefficient encoding.
  function automatic logic [COEF_W-1:0] cbd_coef(input logic [2:0] a, input logic [2:0] b);
    if (a >= b) begin
      return COEF_W'(a - b);
    end
    return COEF_W'(Q - 32'(b - a));
  endfunction

  // Per-polynomial beat cost and input word budget, selected by the latched eta.
  always_comb begin
    cost_c      = CNT_W'(C2);
    words_req_c = WCNT_W'(WORDS2);
`ifdef CBD_ETA3_EN
    if (eta3_q) begin
      cost_c      = CNT_W'(C3);
      words_req_c = WCNT_W'(WORDS3);
    end
`endif
  end

  // Lane decoders: each lane reads its own 2*eta bit group from the buffer bottom.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [3:0]        grp2_c;
    logic [COEF_W-1:0] coef2_c;
    logic [COEF_W-1:0] coef_c;

    assign grp2_c  = buf_q[g*4 +: 4];
    assign coef2_c = cbd_coef(3'(grp2_c[0]) + 3'(grp2_c[1]),
                              3'(grp2_c[2]) + 3'(grp2_c[3]));
`ifdef CBD_ETA3_EN
    logic [5:0]        grp3_c;
    logic [COEF_W-1:0] coef3_c;

    assign grp3_c  = buf_q[g*6 +: 6];
    assign coef3_c = cbd_coef(3'(grp3_c[0]) + 3'(grp3_c[1]) + 3'(grp3_c[2]),
                              3'(grp3_c[3]) + 3'(grp3_c[4]) + 3'(grp3_c[5]));
    assign coef_c  = eta3_q ? coef3_c : coef2_c;
`else
    assign coef_c  = coef2_c;
`endif
    assign out_data_c[g*COEF_W +: COEF_W] = coef_c;
  end

  // Next-state, buffer fill/consume and handshake outputs.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    count_d     = count_q;
    addr_d      = addr_q;
    words_d     = words_q;
`ifdef CBD_ETA3_EN
    eta3_d      = eta3_q;
`endif
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    fire_in_c   = 1'b0;
    fire_out_c  = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          buf_d   = '0;
          count_d = '0;
          addr_d  = '0;
          words_d = '0;
`ifdef CBD_ETA3_EN
          eta3_d  = eta;
`endif
        end
      end

      RUN, DRAIN: begin
        in_ready_c  = (state_q == RUN) && (count_q <= CNT_W'(FILL_MAX)) &&
                      (words_q < words_req_c);
        out_valid_c = (count_q >= cost_c);
        fire_in_c   = in_ready_c && bus.in_valid;
        fire_out_c  = out_valid_c && bus.out_ready;

        // Consume first so a same-cycle fill lands just above the surviving bits.
        if (fire_out_c) begin
          buf_d   = buf_q >> cost_c;
          count_d = count_q - cost_c;
          addr_d  = addr_q + ADDR_W'(1);
        end

        if (fire_in_c) begin
          buf_d   = buf_d | (BUF_W'(bus.in_data) << count_d);
          count_d = count_d + CNT_W'(64);
          words_d = words_q + WCNT_W'(1);
          if (words_d == words_req_c) begin
            state_d = DRAIN;
          end
        end

        // Final beat: drop any leftover bits and return to idle.
        if (fire_out_c && (addr_q == ADDR_W'(N_BEATS - 1))) begin
          done_c  = 1'b1;
          state_d = IDLE;
          buf_d   = '0;
          count_d = '0;
          addr_d  = '0;
          words_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      words_q <= '0;
`ifdef CBD_ETA3_EN
      eta3_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      words_q <= words_d;
`ifdef CBD_ETA3_EN
      eta3_q  <= eta3_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.address   = addr_q;
  assign bus.done      = done_c;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cbd_sampler_param.sv
// Scoreboard bench for cbd_sampler_param: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
`timescale 1ns/1ps
module tb_cbd_sampler_param;

  localparam int unsigned LANES   = 4;
  localparam int unsigned COEF_W  = 12;
  localparam int unsigned N_COEF  = 256;
  localparam int unsigned Q       = 3329;
  localparam int unsigned N_BEATS = N_COEF / LANES;
  localparam int unsigned DW      = LANES * COEF_W;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [5:0]    addr;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic eta;
  logic busy;

  cbd_sampler_param_if #(.LANES(LANES), .COEF_W(COEF_W), .N_COEF(N_COEF)) bus ();

  cbd_sampler_param #(.LANES(LANES), .COEF_W(COEF_W), .N_COEF(N_COEF), .Q(Q)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .eta   (eta),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  beat_t         sb_q[$];
  logic [63:0]   wq[$];
  int            beats_seen = 0;
  int            done_cnt   = 0;
  logic          hold_valid = 1'b0;
  logic [DW-1:0] hold_data  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rep(input int unsigned c);
    return {LANES{COEF_W'(c)}};
  endfunction

  // Same constant coefficient on every lane of every beat.
  task automatic push_const(input int unsigned c);
    beat_t t;
    for (int k = 0; k < int'(N_BEATS); k++) begin
      t.data = rep(c);
      t.addr = 6'(k);
      t.last = (k == int'(N_BEATS) - 1);
      sb_q.push_back(t);
    end
  endtask

  // Alternating words: even word -> 2 on all lanes, odd word -> Q-2 on all lanes (4 beats per word).
  task automatic push_alt();
    beat_t t;
    for (int k = 0; k < int'(N_BEATS); k++) begin
      t.data = (((k / 4) % 2) == 0) ? rep(2) : rep(Q - 2);
      t.addr = 6'(k);
      t.last = (k == int'(N_BEATS) - 1);
      sb_q.push_back(t);
    end
  endtask

  // Reference model: treat the queued words as one LSB-first bit stream.
  task automatic push_model(input int e);
    beat_t       t;
    int          c, base, a, b, coef;
    logic [63:0] w;
    c = 2 * e * int'(LANES);
    for (int k = 0; k < int'(N_BEATS); k++) begin
      t.data = '0;
      for (int i = 0; i < int'(LANES); i++) begin
        a = 0;
        b = 0;
        base = k * c + i * 2 * e;
        for (int j = 0; j < e; j++) begin
          w = wq[(base + j) / 64];
          a += int'(w[(base + j) % 64]);
          w = wq[(base + e + j) / 64];
          b += int'(w[(base + e + j) % 64]);
        end
        coef = (a >= b) ? (a - b) : (int'(Q) - (b - a));
        t.data[i*COEF_W +: COEF_W] = COEF_W'(coef);
      end
      t.addr = 6'(k);
      t.last = (k == int'(N_BEATS) - 1);
      sb_q.push_back(t);
    end
  endtask

  function automatic logic [63:0] eta3_word(input int w);
    logic [63:0] r;
    for (int t = 0; t < 64; t++) r[t] = (((w * 64 + t) % 6) < 3);
    return r;
  endfunction

  // Monitor: compare every accepted beat against the scoreboard; track stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (hold_valid) begin
          check("stall_valid_held", bus.out_valid, 1);
          check("stall_data_stable", bus.out_data, hold_data);
        end
        hold_valid = bus.out_valid && !bus.out_ready;
        hold_data  = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
          check("beat_expected", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            check("beat_data", bus.out_data, sb_q[0].data);
            check("beat_addr_done", {bus.address, bus.done}, {sb_q[0].addr, sb_q[0].last});
            void'(sb_q.pop_front());
          end
          beats_seen++;
          if (bus.done) done_cnt++;
        end else begin
          check("stray_done", bus.done, 0);
        end
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  // Run one polynomial from the word queue; optional stall, abort and busy-start glitch.
  task automatic run_poly(input logic eta_in, input int exp_words, input int stall_at,
                          input int abort_at, input int glitch_at);
    int cyc, acc, b0, d0;
    bit hs, aborted;
    cyc = 0; acc = 0; aborted = 0;
    @(posedge clk); #1;
    b0 = beats_seen;
    d0 = done_cnt;
    start = 1'b1;
    eta   = eta_in;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while ((done_cnt == d0) && (cyc < 400)) begin
      bus.in_valid  = (wq.size() > 0);
      bus.in_data   = (wq.size() > 0) ? wq[0] : 64'd0;
      bus.out_ready = !((stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 10));
      if (cyc == glitch_at) begin
        start = 1'b1;
        eta   = ~eta_in;
      end else begin
        start = 1'b0;
        eta   = eta_in;
      end
      if ((abort_at >= 0) && (beats_seen - b0 == abort_at)) begin
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_address", bus.address, 0);
        check("abort_out_data", bus.out_data, 0);
        aborted = 1;
        break;
      end
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      if ((stall_at >= 0) && (cyc == stall_at + 9)) check("stall_in_ready_low", bus.in_ready, 0);
      @(posedge clk); #1;
      if (hs) begin
        void'(wq.pop_front());
        acc++;
      end
      cyc++;
    end
    start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (aborted) begin
      sb_q.delete();
      repeat (5) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_idle_busy", busy, 0);
    end else begin
      check("done_seen", done_cnt - d0, 1);
      check("words_accepted", acc, exp_words);
      check("beat_count", beats_seen - b0, N_BEATS);
      check("scoreboard_empty", sb_q.size(), 0);
      @(negedge clk);
      check("post_done_busy", busy, 0);
      check("post_done_address", bus.address, 0);
      check("post_done_out_valid", bus.out_valid, 0);
    end
    wq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    eta   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_address", bus.address, 0);
    check("rst_out_data", bus.out_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // All-zero words: every coefficient 0, 16 words consumed.
    for (int i = 0; i < 18; i++) wq.push_back(64'd0);
    push_const(0);
    run_poly(1'b0, 16, -1, -1, -1);

    // 0x3333 / 0xCCCC alternating words: lanes 2 then Q-2.
    for (int i = 0; i < 18; i++)
      wq.push_back(((i % 2) == 0) ? 64'h3333_3333_3333_3333 : 64'hCCCC_CCCC_CCCC_CCCC);
    push_alt();
    run_poly(1'b0, 16, -1, -1, -1);

    // Mixed words with a 10-cycle output stall mid-stream.
    for (int i = 0; i < 18; i++)
      wq.push_back(64'h0123_4567_89AB_CDEF ^ (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1)));
    push_model(2);
    run_poly(1'b0, 16, 20, -1, -1);

    // Reset pulse at beat 20 aborts the polynomial without done.
    for (int i = 0; i < 18; i++) wq.push_back(64'h3333_3333_3333_3333);
    push_const(2);
    run_poly(1'b0, 16, -1, 20, -1);

    // Fresh start after the abort produces a complete polynomial.
    for (int i = 0; i < 18; i++) wq.push_back(64'hCCCC_CCCC_CCCC_CCCC);
    push_const(Q - 2);
    run_poly(1'b0, 16, -1, -1, -1);

    // Start pulsed with eta toggled while busy is ignored.
    for (int i = 0; i < 18; i++) wq.push_back(64'h3333_3333_3333_3333);
    push_const(2);
    run_poly(1'b0, 16, -1, -1, 10);

`ifdef CBD_ETA3_EN
    // eta=3: 6-bit groups 0x07 give 3, all-ones gives 0, 24 words each.
    for (int i = 0; i < 26; i++) wq.push_back(eta3_word(i));
    push_const(3);
    run_poly(1'b1, 24, -1, -1, -1);

    for (int i = 0; i < 26; i++) wq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    push_const(0);
    run_poly(1'b1, 24, -1, -1, -1);
`else
    // eta input has no effect: eta=1 still behaves as eta=2.
    for (int i = 0; i < 18; i++) wq.push_back(64'h3333_3333_3333_3333);
    push_const(2);
    run_poly(1'b1, 16, -1, -1, -1);
    check("eta3_word_unused_pattern", eta3_word(0), 64'h71C7_1C71_C71C_71C7);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
